// File: rtl/dz_egg_ctrl_if.sv
// Button/display bundle of dz_egg_ctrl: raw buttons in, registered count and flags out.
interface dz_egg_ctrl_if;
    logic       btn_add;
    logic       btn_take;
    logic [2:0] num;
    logic       full;
    logic       empty;

    modport master (output btn_add, output btn_take, input num, input full, input empty);
    modport slave  (input btn_add, input btn_take, output num, output full, output empty);
endinterface

// File: rtl/dz_egg_ctrl.sv
// Egg-count controller: debounced add/take buttons drive a saturating 0..MAX_EGGS count.
// Optional idle hatch timer is compiled in with `define EGG_AUTO_HATCH_EN.
module dz_egg_ctrl #(
    parameter int DEB_CYC   = 20,
    parameter int MAX_EGGS  = 4,
    parameter int HATCH_CYC = 3000
) (
    input  logic         clk,
    input  logic         rst,
    dz_egg_ctrl_if.slave bus
);
    if (DEB_CYC < 2 || DEB_CYC > 255 || MAX_EGGS < 1 || MAX_EGGS > 7 ||
        HATCH_CYC < 2 || HATCH_CYC > 65535) begin : g_param_check
        $error("dz_egg_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} deb_state_t;

    localparam logic [7:0] DEB_LAST = 8'(DEB_CYC - 1);
    localparam logic [2:0] NUM_MAX  = 3'(MAX_EGGS);

    // Index 0 is the add button, index 1 the take button.
    logic [1:0] r_s1;
    logic [1:0] r_s2;
    deb_state_t r_st  [2];
    logic [7:0] r_cnt [2];
    logic [1:0] r_pulse;

    logic [2:0] r_num;
    logic       r_full;
    logic       r_empty;

    logic       w_add;
    logic       w_take;
    logic [2:0] w_num_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_pulse <= '0;
            for (int i = 0; i < 2; i++) begin
                r_st[i]  <= IDLE;
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1 <= {bus.btn_take, bus.btn_add};
            r_s2 <= r_s1;
            for (int i = 0; i < 2; i++) begin
                r_pulse[i] <= 1'b0;
                case (r_st[i])
                    IDLE: begin
                        if (r_s2[i]) begin
                            r_st[i]  <= PRESS_CHK;
                            r_cnt[i] <= '0;
                        end
                    end
                    PRESS_CHK: begin
                        if (!r_s2[i]) begin
                            r_st[i] <= IDLE;
                        end else if (r_cnt[i] == DEB_LAST) begin
                            r_st[i]    <= HELD;
                            r_pulse[i] <= 1'b1;
                        end else begin
                            r_cnt[i] <= r_cnt[i] + 8'd1;
                        end
                    end
                    HELD: begin
                        if (!r_s2[i]) begin
                            r_st[i]  <= REL_CHK;
                            r_cnt[i] <= '0;
                        end
                    end
                    REL_CHK: begin
                        if (r_s2[i]) begin
                            r_st[i] <= HELD;
                        end else if (r_cnt[i] == DEB_LAST) begin
                            r_st[i] <= IDLE;
                        end else begin
                            r_cnt[i] <= r_cnt[i] + 8'd1;
                        end
                    end
                    default: r_st[i] <= IDLE;
                endcase
            end
        end
    end

    assign w_add  = r_pulse[0];
    assign w_take = r_pulse[1];

`ifdef EGG_AUTO_HATCH_EN
    localparam logic [15:0] HATCH_LAST = 16'(HATCH_CYC - 1);

    logic [15:0] r_timer;
    logic        w_hatch;

    // A button pulse on the expiry cycle takes priority over hatching.
    assign w_hatch = (r_num != 3'd0) && !w_add && !w_take && (r_timer == HATCH_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= '0;
        end else if (r_num == 3'd0 || w_add || w_take || w_hatch) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 16'd1;
        end
    end
`endif

    always_comb begin
        w_num_next = r_num;
        if (w_add && !w_take && r_num != NUM_MAX) begin
            w_num_next = r_num + 3'd1;
        end else if (w_take && !w_add && r_num != 3'd0) begin
            w_num_next = r_num - 3'd1;
        end
`ifdef EGG_AUTO_HATCH_EN
        if (w_hatch) begin
            w_num_next = r_num - 3'd1;
        end
`endif
    end

    // Flags derive from the next count so they update on the same edge as num.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_num   <= 3'd0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_num   <= w_num_next;
            r_full  <= (w_num_next == NUM_MAX);
            r_empty <= (w_num_next == 3'd0);
        end
    end

    assign bus.num   = r_num;
    assign bus.full  = r_full;
    assign bus.empty = r_empty;
endmodule

// File: tb/tb_dz_egg_ctrl.sv
// Directed bench for dz_egg_ctrl; with EGG_AUTO_HATCH_EN defined it runs the hatch sequence.
module tb_dz_egg_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    dz_egg_ctrl_if bus ();

    dz_egg_ctrl #(
        .DEB_CYC  (20),
        .MAX_EGGS (4),
        .HATCH_CYC(100)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Clean press: hold well past the debounce, then release long enough to reach IDLE.
    task automatic press(input logic a, input logic t);
        bus.btn_add  = a;
        bus.btn_take = t;
        tick(30);
        bus.btn_add  = 1'b0;
        bus.btn_take = 1'b0;
        tick(25);
    endtask

    initial begin
        bus.btn_add  = 1'b0;
        bus.btn_take = 1'b0;
        rst = 1'b1;
        tick(2);
        chk("reset_num", int'(bus.num), 0);
        chk("reset_full", int'(bus.full), 0);
        chk("reset_empty", int'(bus.empty), 1);
        rst = 1'b0;
        tick(2);

`ifdef EGG_AUTO_HATCH_EN
        bus.btn_add = 1'b1;
        tick(24);
        chk("h_add1", int'(bus.num), 1);
        tick(6);
        bus.btn_add = 1'b0;
        tick(30);
        bus.btn_add = 1'b1;
        tick(24);
        chk("h_add2", int'(bus.num), 2);
        tick(6);
        bus.btn_add = 1'b0;
        tick(93);
        chk("h_before_1st", int'(bus.num), 2);
        tick(1);
        chk("h_1st", int'(bus.num), 1);
        tick(99);
        chk("h_before_2nd", int'(bus.num), 1);
        tick(1);
        chk("h_2nd", int'(bus.num), 0);
        tick(150);
        chk("h_hold0", int'(bus.num), 0);
        chk("h_hold0_empty", int'(bus.empty), 1);
        bus.btn_add = 1'b1;
        tick(24);
        chk("h_re_add1", int'(bus.num), 1);
        tick(6);
        bus.btn_add = 1'b0;
        tick(30);
        bus.btn_add = 1'b1;
        tick(24);
        chk("h_re_add2", int'(bus.num), 2);
        tick(6);
        bus.btn_add = 1'b0;
        tick(70);
        bus.btn_add = 1'b1;
        tick(23);
        chk("h_pre_expiry", int'(bus.num), 2);
        tick(1);
        chk("h_button_wins", int'(bus.num), 3);
        tick(6);
        bus.btn_add = 1'b0;
        tick(25);
`else
        bus.btn_add = 1'b1;
        tick(23);
        chk("lat_before", int'(bus.num), 0);
        chk("lat_before_empty", int'(bus.empty), 1);
        tick(1);
        chk("lat_num", int'(bus.num), 1);
        chk("lat_empty", int'(bus.empty), 0);
        chk("lat_full", int'(bus.full), 0);
        tick(6);
        bus.btn_add = 1'b0;
        tick(25);

        press(1'b1, 1'b0);
        chk("add2", int'(bus.num), 2);
        press(1'b1, 1'b0);
        chk("add3", int'(bus.num), 3);
        chk("add3_full", int'(bus.full), 0);
        press(1'b1, 1'b0);
        chk("add4", int'(bus.num), 4);
        chk("add4_full", int'(bus.full), 1);
        press(1'b1, 1'b0);
        chk("add5_sat", int'(bus.num), 4);
        chk("add5_full", int'(bus.full), 1);

        press(1'b0, 1'b1);
        chk("take1", int'(bus.num), 3);
        chk("take1_full", int'(bus.full), 0);
        press(1'b0, 1'b1);
        chk("take2", int'(bus.num), 2);

        bus.btn_take = 1'b1;
        tick(10);
        bus.btn_take = 1'b0;
        tick(40);
        chk("glitch", int'(bus.num), 2);

        for (int k = 0; k < 4; k++) begin
            bus.btn_take = 1'b1;
            tick(2);
            bus.btn_take = 1'b0;
            tick(2);
        end
        bus.btn_take = 1'b1;
        tick(40);
        bus.btn_take = 1'b0;
        tick(25);
        chk("bounce", int'(bus.num), 1);

        press(1'b1, 1'b0);
        chk("add_to2", int'(bus.num), 2);
        press(1'b1, 1'b1);
        chk("both", int'(bus.num), 2);
        press(1'b1, 1'b0);
        chk("add_to3", int'(bus.num), 3);

        bus.btn_add = 1'b1;
        tick(10);
        rst = 1'b1;
        #1;
        chk("rst_num", int'(bus.num), 0);
        chk("rst_empty", int'(bus.empty), 1);
        chk("rst_full", int'(bus.full), 0);
        tick(1);
        rst = 1'b0;
        tick(23);
        chk("held_before", int'(bus.num), 0);
        tick(1);
        chk("held_accept", int'(bus.num), 1);
        tick(6);
        bus.btn_add = 1'b0;
        tick(25);

        press(1'b0, 1'b1);
        chk("take_to0", int'(bus.num), 0);
        chk("take_to0_empty", int'(bus.empty), 1);
        press(1'b0, 1'b1);
        chk("take_sat0", int'(bus.num), 0);
        chk("take_sat0_empty", int'(bus.empty), 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
